// File: rtl/matrix_row_deskewer_if.sv
// Skewed-row input and reassembled-matrix output bundle for matrix_row_deskewer.
// master drives the beats and consumer ready; slave is the deskewer.
interface matrix_row_deskewer_if #(
  parameter int unsigned N          = 3,
  parameter int unsigned DATA_WIDTH = 8
);
  localparam int unsigned Lanes = 2 * N - 1;
  localparam int unsigned RowW  = (N > 1) ? $clog2(N) : 1;

  logic                                   in_valid;
  logic                                   in_ready;
  logic [0:Lanes-1][DATA_WIDTH-1:0]       in_data;
  logic [0:Lanes-1]                       valid_bits_in;
  logic [0:N-1][0:N-1][DATA_WIDTH-1:0]    matrix_out;
  logic                                   out_valid;
  logic                                   out_ready;
  logic [RowW-1:0]                        row_idx;
  logic                                   skew_err;
  logic                                   clr_err;

  modport master (
    output in_valid,
    output in_data,
    output valid_bits_in,
    output out_ready,
    output clr_err,
    input  in_ready,
    input  matrix_out,
    input  out_valid,
    input  row_idx,
    input  skew_err
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  valid_bits_in,
    input  out_ready,
    input  clr_err,
    output in_ready,
    output matrix_out,
    output out_valid,
    output row_idx,
    output skew_err
  );
endinterface

// File: rtl/matrix_row_deskewer.sv
// Rebuilds an N x N matrix from skewed rows (row r on lanes r..r+N-1) and
// presents it as a registered frame with a valid/ready handshake.
module matrix_row_deskewer #(
  parameter int unsigned N          = 3,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  matrix_row_deskewer_if.slave  bus
);
  localparam int unsigned Lanes = 2 * N - 1;
  localparam int unsigned RowW  = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned LaneW = (Lanes > 1) ? $clog2(Lanes) : 1;

  typedef enum logic {StCollect, StFull} state_e;

  state_e                              state_q, state_d;
  logic [RowW-1:0]                     row_q, row_d;
  logic [0:N-1][0:N-1][DATA_WIDTH-1:0] mat_q, mat_d;
  logic                                err_q, err_d;

  logic                                in_ready;
  logic                                accept;
  logic                                mismatch;
  logic [0:Lanes-1]                    exp_mask;
  logic [0:N-1][DATA_WIDTH-1:0]        row_vec;

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    mat_d    = mat_q;
    err_d    = err_q;
    exp_mask = '0;
    row_vec  = '0;

    // In FULL the slot frees as the consumer takes the frame, so a beat can ride along.
    in_ready = (state_q == StCollect) || bus.out_ready;
    accept   = bus.in_valid && in_ready;

    for (int l = 0; l < int'(Lanes); l++) begin
      exp_mask[l] = (l >= int'(row_q)) && (l < int'(row_q) + int'(N));
    end
    mismatch = (exp_mask != bus.valid_bits_in);

    for (int unsigned c = 0; c < N; c++) begin
      row_vec[c] = bus.in_data[LaneW'(row_q) + LaneW'(c)];
    end

    if (state_q == StFull && bus.out_ready) begin
      state_d = StCollect;
    end

    if (accept) begin
      mat_d[row_q] = row_vec;
      if (row_q == RowW'(N - 1)) begin
        row_d   = '0;
        state_d = StFull;
      end else begin
        row_d = row_q + 1'b1;
      end
    end

    // Set beats clear when both happen in the same cycle.
    if (accept && mismatch) begin
      err_d = 1'b1;
    end else if (bus.clr_err) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StCollect;
      row_q   <= '0;
      mat_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      mat_q   <= mat_d;
      err_q   <= err_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = (state_q == StFull);
  assign bus.matrix_out = mat_q;
  assign bus.row_idx    = row_q;
  assign bus.skew_err   = err_q;

endmodule

// File: doc/matrix_row_deskewer.md
Name: matrix_row_deskewer

Overview:
- Inverse of the matrix row shifter: accepts one skewed row per beat on 2N-1 lanes and rebuilds the N x N matrix.
- Row r arrives on lanes r..r+N-1.
- Sits at the output side of the systolic datapath. It realigns skewed result streams into a registered matrix, presented with a valid/ready handshake.

Parameters:
- N, 3, matrix dimension; rows per frame; 2N-1 input lanes.
- DATA_WIDTH, 8, element width in bits.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  beat strobe; a beat is accepted when in_valid && in_ready.
- in_ready  output  1  deskewer can accept a beat.
- in_data  input  [0:2N-2] x DATA_WIDTH  skewed row lanes.
- valid_bits_in  input  [0:2N-2] x 1  per-lane occupancy flags from the shifter.
- matrix_out  output  [0:N-1][0:N-1] x DATA_WIDTH  reassembled matrix, registered.
- out_valid  output  1  matrix_out holds a complete frame.
- out_ready  input  1  consumer accepts the frame; handshake completes when out_valid && out_ready.
- row_idx  output  $clog2(N)  row index of the next beat to be accepted.
- skew_err  output  1  sticky lane-mask mismatch flag.
- clr_err  input  1  synchronous clear of skew_err.

Behaviour:
- Reset (rst_n low, asynchronous) sets:
  - matrix_out to all 0
  - out_valid to 0
  - in_ready to 1
  - row_idx to 0
  - skew_err to 0
  - state to COLLECT
- States are COLLECT and FULL.
- COLLECT:
  - in_ready = 1.
  - On an accepted beat, matrix_out[row_idx][c] <= in_data[row_idx + c] for c = 0..N-1.
  - Lanes outside row_idx..row_idx+N-1 are ignored for data.
  - If row_idx == N-1: row_idx <= 0, state <= FULL, out_valid <= 1 (same edge). Otherwise row_idx <= row_idx + 1.
  - Cycles with in_valid low leave all state unchanged; gaps between beats are legal.
- FULL:
  - out_valid = 1, matrix_out is stable.
  - in_ready = out_ready (combinational). This allows back-to-back frames without a bubble.
  - On out_ready: out_valid <= 0 and state <= COLLECT, unless an input beat is accepted in the same cycle.
  - If an input beat is accepted in the same cycle, it is written as row 0 of the next frame: row_idx <= 1 (or stays FULL if N == 1).
  - Without out_ready, all state holds and in_ready = 0.
- Latency: out_valid rises on the clock edge that accepts the Nth beat, i.e. it is visible the cycle after the last beat is presented.
- Rows 1..N-1 of a previous frame may remain visible in matrix_out while out_valid is 0. Consumers must sample only on out_valid.
- Skew check, on every accepted beat:
  - Expected mask: lanes row_idx..row_idx+N-1 = 1, all others 0.
  - Any difference sets skew_err <= 1 (sticky). Data is still captured and row_idx still advances.
- skew_err clearing:
  - clr_err clears skew_err on the next edge.
  - If clr_err and a new mismatch occur in the same cycle, set wins.
- Reset asserted mid-frame discards the partial frame immediately. The first beat after release is row 0.
- Arithmetic: the lane index row_idx + c is at most 2N-2, so no wrap. row_idx wraps N-1 -> 0 only at frame completion.

Test Plan:
1. Basic frame (N=3): after reset, beats are accepted consecutively with out_ready = 1 held.
   - Beats: in_data [1,2,3,0,0] mask 11100; [0,4,5,6,0] mask 01110; [0,0,7,8,9] mask 00111.
   - Required: out_valid = 1 the cycle after the third beat, matrix_out = [[1,2,3],[4,5,6],[7,8,9]], skew_err = 0, row_idx sequence 0,1,2,0.
2. Backpressure: same frame with out_ready = 0 for 5 cycles and in_valid held high with a new row.
   - Required: in_ready = 0 and matrix_out unchanged for all 5 cycles.
   - Raising out_ready accepts the pending beat as row 0 that same cycle; out_valid drops next cycle; row_idx = 1.
3. Back-to-back frames: two frames streamed with no gaps, out_ready = 1.
   - Second frame is [[10,11,12],[13,14,15],[16,17,18]].
   - Required: out_valid pulses on cycles 3 and 6 after the first beat; the second matrix is exact; no dropped beat.
4. Skew error: row 1 sent with mask 11100.
   - Required: skew_err = 1 from the next cycle and held through frame completion; matrix row 1 still taken from lanes 1..3.
   - clr_err for 1 cycle returns skew_err to 0.
5. Reset mid-frame: accept rows 0 and 1, then pulse rst_n low between clock edges.
   - Required: out_valid = 0, row_idx = 0, matrix_out = 0 immediately, before any clock edge.
   - A full 3-beat frame afterwards yields the correct matrix.
6. Gapped input: in_valid low for 2 cycles between each beat of the frame from scenario 1.
   - Required: same matrix_out, and out_valid rises only after the third accepted beat.
